// File: rtl/ed25519_add_modp_serial.sv
// Digit-serial (A+B) mod p for p = 2^255-19: the sum and the trial subtraction
// of p ripple LSB-first over D-bit digits, one digit per cycle.
module ed25519_add_modp_serial #(
    parameter int W = 255,
    parameter int M = 128,
    parameter int D = 64,
    parameter int N = (W + D) / D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [M-1:0] m_i,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [W-1:0] out0,
    output logic [M-1:0] m_o
);
    localparam int L  = N * D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [255:0] P256  = {1'b0, {247{1'b1}}, 8'hed};
    localparam logic [L-1:0] P_EXT = L'(P256);

    if (N * D < W + 1) begin : g_size_chk
        $error("ed25519_add_modp_serial: N*D must be at least W+1");
    end

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [L-1:0]    a_q, a_d, b_q, b_d, s_q, s_d, t_q, t_d;
    logic            c_q, c_d, bc_q, bc_d;
    logic [M-1:0]    meta_q, meta_d, mo_q, mo_d;
    logic [W-1:0]    out_q, out_d;

    logic [D-1:0]    p_k, s_k, t_k;
    logic            c_n, bc_n;
    logic [L-1:0]    s_full, t_full;

    // Current digit of p, selected by the digit counter.
    always_comb begin
        p_k = '0;
        for (int k = 0; k < N; k++)
            if (cnt_q == CW'(k)) p_k = P_EXT[k*D +: D];
    end

    // t = s - p is formed as s + ~p + 1, the +1 being the initial bc.
    assign {c_n, s_k}  = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, c_q};
    assign {bc_n, t_k} = {1'b0, s_k} + {1'b0, ~p_k} + {{D{1'b0}}, bc_q};
    assign s_full = (s_q >> D) | (L'(s_k) << (L - D));
    assign t_full = (t_q >> D) | (L'(t_k) << (L - D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            t_q     <= '0;
            c_q     <= 1'b0;
            bc_q    <= 1'b0;
            meta_q  <= '0;
            mo_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            t_q     <= t_d;
            c_q     <= c_d;
            bc_q    <= bc_d;
            meta_q  <= meta_d;
            mo_q    <= mo_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        t_d     = t_q;
        c_d     = c_q;
        bc_d    = bc_q;
        meta_d  = meta_q;
        mo_d    = mo_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = L'(in0);
                    b_d     = L'(in1);
                    meta_d  = m_i;
                    s_d     = '0;
                    t_d     = '0;
                    c_d     = 1'b0;
                    bc_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d   = a_q >> D;
                b_d   = b_q >> D;
                s_d   = s_full;
                t_d   = t_full;
                c_d   = c_n;
                bc_d  = bc_n;
                cnt_d = CW'(cnt_q + 1'b1);
                // Final borrow-chain carry set means no borrow, i.e. s >= p.
                if (cnt_q == CW'(N - 1)) begin
                    out_d   = bc_n ? t_full[W-1:0] : s_full[W-1:0];
                    mo_d    = meta_q;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (o_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_ready = (state_q == IDLE);
        o_valid = (state_q == DONE);
        out0    = out_q;
        m_o     = mo_q;
    end
endmodule
